// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, ID register
// locations/values, and register-file reset contents.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_NA,
        ST_IGNORE
    } sccb_tgt_state_t;

    localparam logic [7:0] SCCB_PID_ADDR = 8'h0A;
    localparam logic [7:0] SCCB_PID_VAL  = 8'h76;
    localparam logic [7:0] SCCB_VER_ADDR = 8'h0B;
    localparam logic [7:0] SCCB_VER_VAL  = 8'h73;

    function automatic logic sccb_is_read_only(input logic [7:0] addr);
        return (addr == SCCB_PID_ADDR) || (addr == SCCB_VER_ADDR);
    endfunction

    function automatic logic [7:0] sccb_reg_init(input logic [7:0] addr);
        case (addr)
            SCCB_PID_ADDR: return SCCB_PID_VAL;
            SCCB_VER_ADDR: return SCCB_VER_VAL;
            default:       return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sccb_edge_sync.sv
// Synchronises sioc/siod and turns their transitions into start, stop,
// sioc-rise and sioc-fall pulses, all advancing on clk_en.
module sccb_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic sioc_i,
    input  logic siod_i,
    output logic siod_o,
    output logic start_o,
    output logic stop_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sioc_sync_q;
    logic [SYNC_STAGES-1:0] siod_sync_q;
    logic                   sioc_prev_q;
    logic                   siod_prev_q;
    logic                   sioc_s;
    logic                   siod_s;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else if (clk_en) begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_i};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_i};
            sioc_prev_q <= sioc_s;
            siod_prev_q <= siod_s;
        end
    end

    assign sioc_s  = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s  = siod_sync_q[SYNC_STAGES-1];
    assign siod_o  = siod_s;
    assign start_o = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_o  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
    assign rise_o  = sioc_s & ~sioc_prev_q;
    assign fall_o  = ~sioc_s & sioc_prev_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder with a 256x8 register file (0x0A/0x0B read-only ID bytes).
// Define SCCB_TARGET_AUTOINC_EN for sub-address auto-increment on bursts.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

`ifdef SCCB_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic siod_s, ev_start, ev_stop, ev_rise, ev_fall;

    sccb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .sioc_i  (sioc_i),
        .siod_i  (siod_i),
        .siod_o  (siod_s),
        .start_o (ev_start),
        .stop_o  (ev_stop),
        .rise_o  (ev_rise),
        .fall_o  (ev_fall)
    );

    sccb_tgt_state_t state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      ptr_q;
    logic            rd_q;
    logic            siod_oe_q;
    logic            wr_valid_q;
    logic [7:0]      wr_addr_q;
    logic [7:0]      wr_data_q;
    logic            busy_q;
    logic [7:0]      regs_q [256];

    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       last_bit;

    assign rx_byte  = {shift_q[6:0], siod_s};
    assign tx_byte  = regs_q[ptr_q];
    assign last_bit = (bit_cnt_q == 3'd7);

    // Acks and read data change on sioc fall; bytes are sampled on sioc rise.
    // Each ACK state is left on the 9th rise, and the following state's first
    // fall either releases the line or drives the first read bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            rd_q       <= 1'b0;
            siod_oe_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            for (int i = 0; i < 256; i++) regs_q[i] <= sccb_reg_init(8'(i));
        end else begin
            wr_valid_q <= 1'b0;
            if (clk_en) begin
                if (ev_start) begin
                    state_q   <= ST_DEV;
                    bit_cnt_q <= 3'd0;
                    siod_oe_q <= 1'b0;
                    busy_q    <= 1'b1;
                end else if (ev_stop) begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= 3'd0;
                    siod_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                end else if (ev_fall) begin
                    case (state_q)
                        ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: siod_oe_q <= 1'b1;
                        ST_RDATA: siod_oe_q <= ~tx_byte[3'd7 - bit_cnt_q];
                        default:  siod_oe_q <= 1'b0;
                    endcase
                end else if (ev_rise) begin
                    case (state_q)
                        ST_DEV, ST_SUB, ST_WDATA: begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                if (state_q == ST_DEV) begin
                                    rd_q    <= rx_byte[0];
                                    state_q <= (rx_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                                end else if (state_q == ST_SUB) begin
                                    ptr_q   <= rx_byte;
                                    state_q <= ST_SUB_ACK;
                                end else begin
                                    if (!sccb_is_read_only(ptr_q)) begin
                                        regs_q[ptr_q] <= rx_byte;
                                        wr_valid_q    <= 1'b1;
                                        wr_addr_q     <= ptr_q;
                                        wr_data_q     <= rx_byte;
                                    end
                                    if (AUTOINC) ptr_q <= ptr_q + 8'd1;
                                    state_q <= ST_WDATA_ACK;
                                end
                            end
                        end
                        ST_DEV_ACK: begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= rd_q ? ST_RDATA : ST_SUB;
                        end
                        ST_SUB_ACK: begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_WDATA;
                        end
                        ST_WDATA_ACK: begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= AUTOINC ? ST_WDATA : ST_IGNORE;
                        end
                        ST_RDATA: begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) state_q <= ST_RD_NA;
                        end
                        ST_RD_NA: begin
                            bit_cnt_q <= 3'd0;
                            if (siod_s) begin
                                state_q <= ST_IGNORE;
                            end else begin
                                state_q <= ST_RDATA;
                                if (AUTOINC) ptr_q <= ptr_q + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign siod_oe  = siod_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
